decoder_rr_arbiter: RTL and testbench

// - Round-robin arbiter sharing one resource among 8 requesters; one owner at a time.
// - Drives the existing 3-to-8 active-low decoder (module decoder) to form the grant lines.
//   The decoder is enabled only when its enable input is 2'b10.
// - Sits between the requester bank and the shared resource.
// - Guarantees break-before-make between owners and bounds each grant's length.

---
 rtl/decoder_rr_arbiter_pkg.sv | 13 +
 rtl/decoder_rr_arbiter_dec.sv | 17 +
 rtl/decoder_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin arbiter and its grant decoder.
package decoder_rr_arbiter_pkg;

    localparam int NREQ = 8;
    localparam logic [1:0] DEC_ON = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arbState_t;

endpackage

// File: rtl/decoder_rr_arbiter_dec.sv
// Existing 3-to-8 active-low decoder; drives a single low line only when enabled with DEC_ON.
module decoder
    import decoder_rr_arbiter_pkg::*;
(
    input  logic [2:0] iData,
    input  logic [1:0] iEna,
    output logic [7:0] oData
);

    always_comb begin
        oData = 8'hFF;
        if (iEna == DEC_ON) begin
            oData[iData] = 1'b0;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with bounded hold time and a one-cycle
// all-high gap between owners; the grant lines come from the shared decoder.
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iEna,
    input  logic [NREQ-1:0] iReq,
    input  logic            iRelease,
    output logic [2:0]      oGrantIdx,
    output logic [1:0]      oGrantEna,
    output logic [NREQ-1:0] oGrant_n,
    output logic            oBusy,
    output logic            oTimeout
);

    arbState_t         state;
    arbState_t         nextState;
    logic [2:0]        ptr;
    logic [2:0]        ptrNext;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] holdNext;
    logic [2:0]        idxNext;
    logic [1:0]        enaNext;
    logic              busyNext;
    logic              timeoutNext;
    logic [3:0]        pick;
    logic              winFound;
    logic [2:0]        winIdx;
    logic              timeoutHit;
    logic              exitGrant;

    // Scan from the highest offset down so the request closest to ptr is written last and wins.
    function automatic logic [3:0] pickWinner(input logic [NREQ-1:0] req, input logic [2:0] start);
        logic [2:0] idx;
        logic [3:0] result;
        result = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = start + 3'(i);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    always_comb begin
        pick       = pickWinner(iReq, ptr);
        winFound   = pick[3];
        winIdx     = pick[2:0];
        timeoutHit = (hold == HOLD_W'(MAX_HOLD - 1));
        exitGrant  = !iEna || iRelease || !iReq[oGrantIdx] || timeoutHit;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, GAP: nextState = (iEna && winFound) ? GRANT : IDLE;
            GRANT:     nextState = exitGrant ? GAP : GRANT;
            default:   nextState = IDLE;
        endcase
    end

    // The timeout pulse is registered at the exit edge, so it shows up in the GAP cycle.
    always_comb begin
        idxNext     = oGrantIdx;
        ptrNext     = ptr;
        holdNext    = hold;
        enaNext     = 2'b00;
        busyNext    = 1'b0;
        timeoutNext = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (nextState == GRANT) begin
                    idxNext  = winIdx;
                    holdNext = '0;
                    enaNext  = DEC_ON;
                    busyNext = 1'b1;
                end
            end
            GRANT: begin
                holdNext = hold + 1'b1;
                if (exitGrant) begin
                    ptrNext     = oGrantIdx + 3'd1;
                    idxNext     = 3'd0;
                    timeoutNext = timeoutHit && iEna && !iRelease && iReq[oGrantIdx];
                end else begin
                    enaNext  = DEC_ON;
                    busyNext = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold      <= '0;
            oGrantIdx <= 3'd0;
            oGrantEna <= 2'b00;
            oBusy     <= 1'b0;
            oTimeout  <= 1'b0;
        end else begin
            state     <= nextState;
            ptr       <= ptrNext;
            hold      <= holdNext;
            oGrantIdx <= idxNext;
            oGrantEna <= enaNext;
            oBusy     <= busyNext;
            oTimeout  <= timeoutNext;
        end
    end

    decoder u_dec (
        .iData(oGrantIdx),
        .iEna (oGrantEna),
        .oData(oGrant_n)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed scoreboard bench for decoder_rr_arbiter: each step drives one cycle of inputs,
// queues the outputs expected after that edge, and checks them just after the edge.
module tb_decoder_rr_arbiter;

    typedef struct {
        string      tag;
        logic [2:0] idx;
        logic       busy;
        logic       timeout;
    } expect_t;

    logic       iClk;
    logic       iRst;
    logic       iEna;
    logic [7:0] iReq;
    logic       iRelease;
    logic [2:0] oGrantIdx;
    logic [1:0] oGrantEna;
    logic [7:0] oGrant_n;
    logic       oBusy;
    logic       oTimeout;

    expect_t sb[$];
    int      compared;
    int      mismatched;

    decoder_rr_arbiter #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEna     (iEna),
        .iReq     (iReq),
        .iRelease (iRelease),
        .oGrantIdx(oGrantIdx),
        .oGrantEna(oGrantEna),
        .oGrant_n (oGrant_n),
        .oBusy    (oBusy),
        .oTimeout (oTimeout)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic compareOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expect_t    e;
        logic [7:0] expGrant;
        logic [7:0] oneHot;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e        = sb.pop_front();
            oneHot   = 8'd1 << e.idx;
            expGrant = e.busy ? ~oneHot : 8'hFF;
            compareOne({e.tag, ".idx"},     8'(oGrantIdx), 8'(e.idx));
            compareOne({e.tag, ".busy"},    8'(oBusy),     8'(e.busy));
            compareOne({e.tag, ".ena"},     8'(oGrantEna), e.busy ? 8'h02 : 8'h00);
            compareOne({e.tag, ".grant_n"}, oGrant_n,      expGrant);
            compareOne({e.tag, ".timeout"}, 8'(oTimeout),  8'(e.timeout));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic ena,
                                 input logic [7:0] req, input logic rel,
                                 input logic [2:0] expIdx, input logic expBusy,
                                 input logic expTimeout);
        expect_t e;
        @(negedge iClk);
        iRst     = rst;
        iEna     = ena;
        iReq     = req;
        iRelease = rel;
        e.tag     = tag;
        e.idx     = expIdx;
        e.busy    = expBusy;
        e.timeout = expTimeout;
        sb.push_back(e);
        @(posedge iClk);
        #1;
        checkOutput();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        iRst       = 1'b1;
        iEna       = 1'b1;
        iReq       = 8'hFF;
        iRelease   = 1'b0;

        applyStimulus("reset0", 1, 1, 8'hFF, 0, 3'd0, 0, 0);
        applyStimulus("reset1", 1, 1, 8'hFF, 0, 3'd0, 0, 0);
        applyStimulus("firstGrant", 0, 1, 8'hFF, 0, 3'd0, 1, 0);

        // Fairness: every owner holds two cycles, then the gap, then the next index.
        for (int k = 0; k < 8; k++) begin
            applyStimulus($sformatf("fair%0d.hold", k), 0, 1, 8'hFF, 0, 3'(k), 1, 0);
            applyStimulus($sformatf("fair%0d.gap", k), 0, 1, 8'hFF, 1, 3'd0, 0, 0);
            applyStimulus($sformatf("fair%0d.next", k), 0, 1, 8'hFF, 0, 3'((k + 1) % 8), 1, 0);
        end

        // Steer ptr to 6 by granting and releasing owner 5, then check the circular wrap.
        applyStimulus("wrap.rel0", 0, 1, 8'hFF, 1, 3'd0, 0, 0);
        applyStimulus("wrap.grant5", 0, 1, 8'h20, 0, 3'd5, 1, 0);
        applyStimulus("wrap.rel5", 0, 1, 8'h20, 1, 3'd0, 0, 0);
        applyStimulus("wrap.grant0", 0, 1, 8'h05, 0, 3'd0, 1, 0);
        applyStimulus("wrap.relA", 0, 1, 8'h05, 1, 3'd0, 0, 0);
        applyStimulus("wrap.grant2", 0, 1, 8'h05, 0, 3'd2, 1, 0);
        applyStimulus("wrap.relB", 0, 1, 8'h05, 1, 3'd0, 0, 0);
        applyStimulus("wrap.idle", 0, 1, 8'h00, 0, 3'd0, 0, 0);

        applyStimulus("to.grant3", 0, 1, 8'h08, 0, 3'd3, 1, 0);
        for (int c = 1; c <= 14; c++) begin
            applyStimulus($sformatf("to.hold%0d", c), 0, 1, 8'h08, 0, 3'd3, 1, 0);
        end
        applyStimulus("to.pulse", 0, 1, 8'h08, 0, 3'd0, 0, 1);
        applyStimulus("to.regrant3", 0, 1, 8'h08, 0, 3'd3, 1, 0);

        // Release lands in the cycle that would otherwise time out: no pulse allowed.
        for (int c = 1; c <= 14; c++) begin
            applyStimulus($sformatf("sim.hold%0d", c), 0, 1, 8'h08, 0, 3'd3, 1, 0);
        end
        applyStimulus("sim.release15", 0, 1, 8'h08, 1, 3'd0, 0, 0);

        applyStimulus("ena.grant3", 0, 1, 8'h08, 0, 3'd3, 1, 0);
        applyStimulus("ena.hold", 0, 1, 8'h08, 0, 3'd3, 1, 0);
        applyStimulus("ena.drop", 0, 0, 8'h08, 0, 3'd0, 0, 0);
        applyStimulus("ena.blocked0", 0, 0, 8'h08, 0, 3'd0, 0, 0);
        applyStimulus("ena.blockedRel", 0, 0, 8'h08, 1, 3'd0, 0, 0);
        applyStimulus("ena.relIgnored", 0, 1, 8'h08, 1, 3'd3, 1, 0);
        applyStimulus("impl.reqDrop", 0, 1, 8'h00, 0, 3'd0, 0, 0);
        applyStimulus("impl.idle", 0, 1, 8'h00, 0, 3'd0, 0, 0);

        applyStimulus("rst.grant5", 0, 1, 8'h20, 0, 3'd5, 1, 0);
        applyStimulus("rst.mid", 1, 1, 8'hFF, 0, 3'd0, 0, 0);
        applyStimulus("rst.after", 0, 1, 8'hFF, 0, 3'd0, 1, 0);

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard.drain: observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
